data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Single-port data memory controller for an RV32 load/store unit. It accepts
// one request at a time through a valid/ready handshake, performs byte-lane
// stores and sign/zero-extending loads, and flags misaligned or illegal
// accesses as faults. Each request gets exactly one response pulse.
//
// Parameters
//   ADDR_WIDTH  request byte-address width
//   MEM_DEPTH   number of 32-bit words (power of two, >= 4)
//   RD_LATENCY  load response latency in cycles (1 or 2)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   controller idle and able to accept a request
//   req_we      1 = store, 0 = load
//   req_funct3  RV32 width/sign code
//   req_addr    byte address (wraps modulo 4*MEM_DEPTH)
//   req_wdata   right-aligned store data
//   resp_valid  one-cycle response pulse
//   resp_rdata  load result (0 for stores, faults and outside the pulse)
//   resp_fault  request was misaligned or illegal
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [31:0] r_mem [MEM_DEPTH];

  logic [31:0] r_rdata1;
  logic [31:0] r_rdata2;
  logic        r_fault;
  logic        r_useStage2;

  logic [IDX_W-1:0] w_wordIdx;
  logic [1:0]       w_offset;
  logic             w_accept;
  logic             w_fault;
  logic             w_doStore;
  logic [3:0]       w_storeBe;
  logic [31:0]      w_storeData;
  logic [31:0]      w_loadWord;
  logic [31:0]      w_loadShifted;
  logic [31:0]      w_loadData;
  logic             w_unusedAddr;

  // Address bits above the word index are deliberately ignored (wrap-around).
  assign w_unusedAddr = &{1'b0, req_addr};

  assign w_wordIdx = req_addr[IDX_W+1:2];
  assign w_offset  = req_addr[1:0];

  // Acceptance is only possible in IDLE, so requests presented while busy
  // are simply not seen.
  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_doStore = w_accept && req_we && !w_fault;

  // Misalignment / illegal funct3 detection.
  always_comb begin
    w_fault = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000:  w_fault = 1'b0;
        3'b001:  w_fault = w_offset[0];
        3'b010:  w_fault = (w_offset != 2'b00);
        default: w_fault = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: w_fault = 1'b0;
        3'b001, 3'b101: w_fault = w_offset[0];
        3'b010:         w_fault = (w_offset != 2'b00);
        default:        w_fault = 1'b1;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick
  // which lanes change.
  always_comb begin
    w_storeBe   = 4'b0000;
    w_storeData = 32'h0;
    case (req_funct3)
      3'b000: begin
        w_storeBe   = 4'b0001 << w_offset;
        w_storeData = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        w_storeBe   = 4'b0011 << {w_offset[1], 1'b0};
        w_storeData = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        w_storeBe   = 4'b1111;
        w_storeData = req_wdata;
      end
      default: begin
        w_storeBe   = 4'b0000;
        w_storeData = 32'h0;
      end
    endcase
  end

  // Load extraction: shift the addressed lane(s) down to bit 0, then extend.
  assign w_loadWord    = r_mem[w_wordIdx];
  assign w_loadShifted = w_loadWord >> {w_offset, 3'b000};

  always_comb begin
    w_loadData = 32'h0;
    case (req_funct3)
      3'b000:  w_loadData = {{24{w_loadShifted[7]}}, w_loadShifted[7:0]};
      3'b001:  w_loadData = {{16{w_loadShifted[15]}}, w_loadShifted[15:0]};
      3'b010:  w_loadData = w_loadShifted;
      3'b100:  w_loadData = {24'h0, w_loadShifted[7:0]};
      3'b101:  w_loadData = {16'h0, w_loadShifted[15:0]};
      default: w_loadData = 32'h0;
    endcase
  end

  // Memory array has no reset; stores commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (w_doStore) begin
      for (int i = 0; i < 4; i++) begin
        if (w_storeBe[i]) begin
          r_mem[w_wordIdx][8*i +: 8] <= w_storeData[8*i +: 8];
        end
      end
    end
  end

  // Response pipeline. Stage 1 captures at acceptance; stage 2 is only
  // used by non-faulting loads when the latency is two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata1    <= 32'h0;
      r_rdata2    <= 32'h0;
      r_fault     <= 1'b0;
      r_useStage2 <= 1'b0;
    end else if (w_accept) begin
      r_rdata1    <= (req_we || w_fault) ? 32'h0 : w_loadData;
      r_rdata2    <= 32'h0;
      r_fault     <= w_fault;
      r_useStage2 <= (RD_LATENCY == 2) && !req_we && !w_fault;
    end else if (r_state == ACCESS) begin
      r_rdata2    <= r_rdata1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and outputs; response fields are forced to zero outside RESP.
  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = 32'h0;
    resp_fault  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_we || w_fault || (RD_LATENCY != 2)) begin
            w_nextState = RESP;
          end else begin
            w_nextState = ACCESS;
          end
        end
      end
      ACCESS: begin
        w_nextState = RESP;
      end
      RESP: begin
        resp_valid  = 1'b1;
        resp_rdata  = r_useStage2 ? r_rdata2 : r_rdata1;
        resp_fault  = r_fault;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Directed self-checking bench for data_mem_ctrl. Two instances run side by
// side: dutA with RD_LATENCY=1 and dutB with RD_LATENCY=2, each with its own
// request signals. Responses are packed as {valid, fault, rdata} and sampled
// on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        aValid, aWe, aReady, aRespValid, aFault;
  logic [2:0]  aF3;
  logic [31:0] aAddr, aWdata, aRdata;

  logic        bValid, bWe, bReady, bRespValid, bFault;
  logic [2:0]  bF3;
  logic [31:0] bAddr, bWdata, bRdata;

  int checks   = 0;
  int failures = 0;

  localparam logic [33:0] FAULT_RESP = {2'b11, 32'h0};

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [33:0] exp;
    logic [1:0]  lat;
  } vec_t;

  data_mem_ctrl #(.ADDR_WIDTH(32), .MEM_DEPTH(256), .RD_LATENCY(1)) dutA (
    .clk(clk), .rst_n(rst_n),
    .req_valid(aValid), .req_ready(aReady), .req_we(aWe), .req_funct3(aF3),
    .req_addr(aAddr), .req_wdata(aWdata),
    .resp_valid(aRespValid), .resp_rdata(aRdata), .resp_fault(aFault)
  );

  data_mem_ctrl #(.ADDR_WIDTH(32), .MEM_DEPTH(256), .RD_LATENCY(2)) dutB (
    .clk(clk), .rst_n(rst_n),
    .req_valid(bValid), .req_ready(bReady), .req_we(bWe), .req_funct3(bF3),
    .req_addr(bAddr), .req_wdata(bWdata),
    .resp_valid(bRespValid), .resp_rdata(bRdata), .resp_fault(bFault)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] okResp(input logic [31:0] d);
    return {2'b10, d};
  endfunction

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [33:0] exp, input logic [1:0] lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // Issue one request on the chosen DUT and sample the response
  // waitCycles falling edges after the acceptance edge.
  task automatic doReq(input bit useB, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int waitCycles, output logic [33:0] resp);
    @(negedge clk);
    if (useB) begin
      bValid = 1'b1; bWe = we; bF3 = f3; bAddr = addr; bWdata = wdata;
    end else begin
      aValid = 1'b1; aWe = we; aF3 = f3; aAddr = addr; aWdata = wdata;
    end
    @(negedge clk);
    aValid = 1'b0;
    bValid = 1'b0;
    for (int i = 1; i < waitCycles; i++) @(negedge clk);
    resp = useB ? {bRespValid, bFault, bRdata} : {aRespValid, aFault, aRdata};
  endtask

  task automatic test_reset();
    logic [34:0] obs;
    #12;
    obs = {aReady, aRespValid, aFault, aRdata};
    checks++;
    if (obs !== {3'b100, 32'h0}) begin
      failures++; $display("[TB] FAIL reset_a: got %h want %h", obs, {3'b100, 32'h0});
    end
    obs = {bReady, bRespValid, bFault, bRdata};
    checks++;
    if (obs !== {3'b100, 32'h0}) begin
      failures++; $display("[TB] FAIL reset_b: got %h want %h", obs, {3'b100, 32'h0});
    end
    // Request already present when reset releases: taken on the first edge.
    @(negedge clk);
    aValid = 1'b1; aWe = 1'b1; aF3 = 3'b010; aAddr = 32'h40; aWdata = 32'h1234_5678;
    rst_n = 1'b1;
    @(negedge clk);
    aValid = 1'b0;
    obs = {aReady, aRespValid, aFault, aRdata};
    checks++;
    if (obs !== {3'b010, 32'h0}) begin
      failures++; $display("[TB] FAIL first_edge_accept: got %h want %h", obs, {3'b010, 32'h0});
    end
    doReq(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, 1, obs[33:0]);
    checks++;
    if (obs[33:0] !== okResp(32'h1234_5678)) begin
      failures++; $display("[TB] FAIL first_edge_readback: got %h want %h", obs[33:0], okResp(32'h1234_5678));
    end
  endtask

  task automatic test_load_ext();
    vec_t v[$];
    logic [33:0] r;
    v.push_back(mk(1'b1, 3'b010, 32'h10, 32'h8000_00FF, okResp(32'h0), 2'd1));
    v.push_back(mk(1'b0, 3'b000, 32'h10, 32'h0, okResp(32'hFFFF_FFFF), 2'd1));
    v.push_back(mk(1'b0, 3'b100, 32'h10, 32'h0, okResp(32'h0000_00FF), 2'd1));
    v.push_back(mk(1'b0, 3'b001, 32'h10, 32'h0, okResp(32'h0000_00FF), 2'd1));
    v.push_back(mk(1'b0, 3'b101, 32'h10, 32'h0, okResp(32'h0000_00FF), 2'd1));
    v.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0, okResp(32'h8000_00FF), 2'd1));
    v.push_back(mk(1'b0, 3'b001, 32'h12, 32'h0, okResp(32'hFFFF_8000), 2'd1));
    v.push_back(mk(1'b0, 3'b101, 32'h12, 32'h0, okResp(32'h0000_8000), 2'd1));
    v.push_back(mk(1'b0, 3'b000, 32'h13, 32'h0, okResp(32'hFFFF_FF80), 2'd1));
    foreach (v[i]) begin
      doReq(1'b0, v[i].we, v[i].f3, v[i].addr, v[i].wdata, 1, r);
      checks++;
      if (r !== v[i].exp) begin
        failures++; $display("[TB] FAIL load_ext[%0d]: got %h want %h", i, r, v[i].exp);
      end
    end
  endtask

  task automatic test_store_lanes();
    vec_t v[$];
    logic [33:0] r;
    v.push_back(mk(1'b1, 3'b010, 32'h20, 32'h0000_0000, okResp(32'h0), 2'd1));
    v.push_back(mk(1'b1, 3'b000, 32'h22, 32'h0000_00AB, okResp(32'h0), 2'd1));
    v.push_back(mk(1'b1, 3'b001, 32'h20, 32'h0000_1234, okResp(32'h0), 2'd1));
    v.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0, okResp(32'h00AB_1234), 2'd1));
    v.push_back(mk(1'b0, 3'b001, 32'h22, 32'h0, okResp(32'h0000_00AB), 2'd1));
    v.push_back(mk(1'b1, 3'b000, 32'h23, 32'hFFFF_FF11, okResp(32'h0), 2'd1));
    v.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0, okResp(32'h11AB_1234), 2'd1));
    v.push_back(mk(1'b0, 3'b101, 32'h22, 32'h0, okResp(32'h0000_11AB), 2'd1));
    foreach (v[i]) begin
      doReq(1'b0, v[i].we, v[i].f3, v[i].addr, v[i].wdata, 1, r);
      checks++;
      if (r !== v[i].exp) begin
        failures++; $display("[TB] FAIL store_lanes[%0d]: got %h want %h", i, r, v[i].exp);
      end
    end
  endtask

  task automatic test_faults();
    vec_t v[$];
    logic [33:0] r;
    v.push_back(mk(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, okResp(32'h0), 2'd1));
    v.push_back(mk(1'b1, 3'b001, 32'h31, 32'h0000_FFFF, FAULT_RESP, 2'd1));
    v.push_back(mk(1'b1, 3'b010, 32'h32, 32'h1111_1111, FAULT_RESP, 2'd1));
    v.push_back(mk(1'b0, 3'b011, 32'h30, 32'h0, FAULT_RESP, 2'd1));
    v.push_back(mk(1'b1, 3'b100, 32'h30, 32'h2222_2222, FAULT_RESP, 2'd1));
    v.push_back(mk(1'b0, 3'b001, 32'h33, 32'h0, FAULT_RESP, 2'd1));
    v.push_back(mk(1'b0, 3'b110, 32'h30, 32'h0, FAULT_RESP, 2'd1));
    v.push_back(mk(1'b0, 3'b010, 32'h30, 32'h0, okResp(32'hCAFE_F00D), 2'd1));
    foreach (v[i]) begin
      doReq(1'b0, v[i].we, v[i].f3, v[i].addr, v[i].wdata, 1, r);
      checks++;
      if (r !== v[i].exp) begin
        failures++; $display("[TB] FAIL faults[%0d]: got %h want %h", i, r, v[i].exp);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t v[$];
    logic [33:0] r;
    v.push_back(mk(1'b1, 3'b010, 32'h0000_0404, 32'h5555_AAAA, okResp(32'h0), 2'd1));
    v.push_back(mk(1'b0, 3'b010, 32'h0000_0004, 32'h0, okResp(32'h5555_AAAA), 2'd1));
    v.push_back(mk(1'b0, 3'b010, 32'hFFFF_FC04, 32'h0, okResp(32'h5555_AAAA), 2'd1));
    v.push_back(mk(1'b1, 3'b000, 32'h0000_0007, 32'h0000_0099, okResp(32'h0), 2'd1));
    v.push_back(mk(1'b0, 3'b010, 32'h0000_0404, 32'h0, okResp(32'h9955_AAAA), 2'd1));
    foreach (v[i]) begin
      doReq(1'b0, v[i].we, v[i].f3, v[i].addr, v[i].wdata, 1, r);
      checks++;
      if (r !== v[i].exp) begin
        failures++; $display("[TB] FAIL wrap[%0d]: got %h want %h", i, r, v[i].exp);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [33:0] r;
    logic [34:0] obs;
    doReq(1'b0, 1'b1, 3'b010, 32'h54, 32'h3333_3333, 1, r);
    @(negedge clk);
    aValid = 1'b1; aWe = 1'b1; aF3 = 3'b010; aAddr = 32'h50; aWdata = 32'h1111_1111;
    @(negedge clk);
    obs = {aReady, aRespValid, aFault, aRdata};
    checks++;
    if (obs !== {3'b010, 32'h0}) begin
      failures++; $display("[TB] FAIL busy_resp: got %h want %h", obs, {3'b010, 32'h0});
    end
    // Still presenting a different store while the controller is busy.
    aAddr = 32'h54; aWdata = 32'h2222_2222;
    @(negedge clk);
    obs = {aReady, aRespValid, aFault, aRdata};
    checks++;
    if (obs !== {3'b100, 32'h0}) begin
      failures++; $display("[TB] FAIL busy_after: got %h want %h", obs, {3'b100, 32'h0});
    end
    aValid = 1'b0;
    doReq(1'b0, 1'b0, 3'b010, 32'h50, 32'h0, 1, r);
    checks++;
    if (r !== okResp(32'h1111_1111)) begin
      failures++; $display("[TB] FAIL busy_first: got %h want %h", r, okResp(32'h1111_1111));
    end
    doReq(1'b0, 1'b0, 3'b010, 32'h54, 32'h0, 1, r);
    checks++;
    if (r !== okResp(32'h3333_3333)) begin
      failures++; $display("[TB] FAIL busy_ignored: got %h want %h", r, okResp(32'h3333_3333));
    end
  endtask

  task automatic test_latency2();
    vec_t v[$];
    logic [33:0] r;
    logic [34:0] obs;
    logic [34:0] want [3];
    doReq(1'b1, 1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 1, r);
    checks++;
    if (r !== okResp(32'h0)) begin
      failures++; $display("[TB] FAIL lat2_store: got %h want %h", r, okResp(32'h0));
    end
    want[0] = {3'b000, 32'h0};
    want[1] = {3'b010, 32'hDEAD_BEEF};
    want[2] = {3'b100, 32'h0};
    @(negedge clk);
    bValid = 1'b1; bWe = 1'b0; bF3 = 3'b010; bAddr = 32'h8;
    @(negedge clk);
    bValid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      obs = {bReady, bRespValid, bFault, bRdata};
      checks++;
      if (obs !== want[c]) begin
        failures++; $display("[TB] FAIL lat2_cycle%0d: got %h want %h", c + 1, obs, want[c]);
      end
      if (c < 2) @(negedge clk);
    end
    v.push_back(mk(1'b0, 3'b000, 32'hB, 32'h0, okResp(32'hFFFF_FFDE), 2'd2));
    v.push_back(mk(1'b0, 3'b101, 32'hA, 32'h0, okResp(32'h0000_DEAD), 2'd2));
    v.push_back(mk(1'b0, 3'b010, 32'h9, 32'h0, FAULT_RESP, 2'd1));
    v.push_back(mk(1'b1, 3'b000, 32'h8, 32'h0000_0042, okResp(32'h0), 2'd1));
    v.push_back(mk(1'b0, 3'b010, 32'h8, 32'h0, okResp(32'hDEAD_BE42), 2'd2));
    foreach (v[i]) begin
      doReq(1'b1, v[i].we, v[i].f3, v[i].addr, v[i].wdata, int'(v[i].lat), r);
      checks++;
      if (r !== v[i].exp) begin
        failures++; $display("[TB] FAIL lat2[%0d]: got %h want %h", i, r, v[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [33:0] r;
    logic [34:0] obs;
    // Reset during a store's RESP: response dropped, store kept.
    @(negedge clk);
    aValid = 1'b1; aWe = 1'b1; aF3 = 3'b010; aAddr = 32'h60; aWdata = 32'h600D_600D;
    @(negedge clk);
    aValid = 1'b0;
    rst_n = 1'b0;
    #1;
    obs = {aReady, aRespValid, aFault, aRdata};
    checks++;
    if (obs !== {3'b100, 32'h0}) begin
      failures++; $display("[TB] FAIL rstmid_a: got %h want %h", obs, {3'b100, 32'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    doReq(1'b0, 1'b0, 3'b010, 32'h60, 32'h0, 1, r);
    checks++;
    if (r !== okResp(32'h600D_600D)) begin
      failures++; $display("[TB] FAIL rstmid_store_kept: got %h want %h", r, okResp(32'h600D_600D));
    end
    // Reset while dutB is in ACCESS.
    @(negedge clk);
    bValid = 1'b1; bWe = 1'b0; bF3 = 3'b010; bAddr = 32'h8;
    @(negedge clk);
    bValid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    obs = {bReady, bRespValid, bFault, bRdata};
    checks++;
    if (obs !== {3'b100, 32'h0}) begin
      failures++; $display("[TB] FAIL rstmid_b_during: got %h want %h", obs, {3'b100, 32'h0});
    end
    @(negedge clk);
    obs = {bReady, bRespValid, bFault, bRdata};
    checks++;
    if (obs !== {3'b100, 32'h0}) begin
      failures++; $display("[TB] FAIL rstmid_b_held: got %h want %h", obs, {3'b100, 32'h0});
    end
    rst_n = 1'b1;
    @(negedge clk);
    obs = {bReady, bRespValid, bFault, bRdata};
    checks++;
    if (obs !== {3'b100, 32'h0}) begin
      failures++; $display("[TB] FAIL rstmid_b_after: got %h want %h", obs, {3'b100, 32'h0});
    end
    doReq(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 2, r);
    checks++;
    if (r !== okResp(32'hDEAD_BE42)) begin
      failures++; $display("[TB] FAIL rstmid_b_load: got %h want %h", r, okResp(32'hDEAD_BE42));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    aValid = 1'b0; aWe = 1'b0; aF3 = 3'b000; aAddr = 32'h0; aWdata = 32'h0;
    bValid = 1'b0; bWe = 1'b0; bF3 = 3'b000; bAddr = 32'h0; bWdata = 32'h0;
    test_reset();
    test_load_ext();
    test_store_lanes();
    test_faults();
    test_wrap();
    test_busy_ignore();
    test_latency2();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
